vga_rx_monitor: RTL

//  Receive end of the VGA link: samples RED/GREEN/BLUE/HSYNC/VSYNC as the VGA controller drives them to the monitor.

---
 rtl/vga_rx_monitor.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: receive side of the VGA link.
// Registers RGB/HSYNC/VSYNC, recovers the line and frame counters, verifies the
// timing against the configured mode and re-emits visible pixels with x/y.
// Latency from input sample to pix_* is two clocks.
// Optional build macro VGA_RX_CELL_EN adds cell-centre sampling outputs
// (cell_x, cell_y, cell_valid, cell_on) for grid capture.
module vga_rx_monitor #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
`ifdef VGA_RX_CELL_EN
  ,
  parameter int unsigned CELL_SIZE = 16
`endif
) (
  input  logic       vga_clk,
  input  logic       rst_n,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       err_clr,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [2:0] pix_rgb,
  output logic       frame_done,
  output logic       locked,
  output logic       timing_err
`ifdef VGA_RX_CELL_EN
  ,
  output logic [5:0] cell_x,
  output logic [5:0] cell_y,
  output logic       cell_valid,
  output logic       cell_on
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_TMO  = 11'(2 * H_TOTAL);
  localparam logic [10:0] H_VIS0 = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_VIS1 = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_VIS1 = 10'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    MEASURE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // stage-1 registers (aligned with the sampled pixel)
  logic        hs1;
  logic [2:0]  rgb1;
  logic        vs_last;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        fstart1;
  logic        line_bad1;
  logic        frame_bad1;
  logic        meas_bad;

  // derived
  logic        fall_in;
  logic        fs_in;
  logic        fail;
  logic        timeout1;
  logic        vis1;
  logic        lock_nxt;
  logic [9:0]  px;
  logic [9:0]  py;

  // Sync edge and frame-start detection on the raw inputs so that the
  // counters land in stage 1 already aligned with the pixel they describe.
  always_comb begin
    fall_in = hs1 & ~hsync;
    fs_in   = fall_in & ~vsync & vs_last;
  end

  // Stage 1: input registers, line/frame counters and check flags.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1        <= 1'b0;
      rgb1       <= '0;
      vs_last    <= 1'b0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      fstart1    <= 1'b0;
      line_bad1  <= 1'b0;
      frame_bad1 <= 1'b0;
    end else begin
      hs1        <= hsync;
      rgb1       <= {red, green, blue};
      fstart1    <= fs_in;
      line_bad1  <= fall_in && (h_cnt != H_LAST);
      frame_bad1 <= fs_in && (v_cnt != V_LAST);
      if (fall_in) begin
        h_cnt   <= '0;
        vs_last <= vsync;
        v_cnt   <= fs_in ? '0 : v_cnt + 10'd1;
      end else if (h_cnt != '1) begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // Stage-1 decode: check result, sync-loss timeout, visible window, position.
  always_comb begin
    fail     = line_bad1 | frame_bad1;
    timeout1 = (h_cnt == H_TMO);
    vis1     = (h_cnt >= H_VIS0) && (h_cnt < H_VIS1) &&
               (v_cnt >= V_VIS0) && (v_cnt < V_VIS1);
    px       = 10'(h_cnt - H_VIS0);
    py       = v_cnt - V_VIS0;
  end

  // FSM state register.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= UNLOCKED;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state; sync loss overrides every other transition.
  always_comb begin
    state_nxt = state;
    unique case (state)
      UNLOCKED: if (fstart1) state_nxt = MEASURE;
      MEASURE:  if (fstart1 && !meas_bad && !fail) state_nxt = LOCKED;
      LOCKED:   if (fail) state_nxt = MEASURE;
      default:  state_nxt = UNLOCKED;
    endcase
    if (timeout1) begin
      state_nxt = UNLOCKED;
    end
  end

  // FSM outputs; stage-2 gating uses the state being entered so pixel and
  // frame_done qualifiers line up with the locked flag they appear beside.
  always_comb begin
    locked   = (state == LOCKED);
    lock_nxt = (state_nxt == LOCKED);
  end

  // Failures seen during the current measurement frame; cleared on entry to
  // MEASURE and at every frame start so each frame is judged on its own.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_bad <= 1'b0;
    end else if (state == MEASURE && !fstart1) begin
      meas_bad <= meas_bad | fail;
    end else begin
      meas_bad <= 1'b0;
    end
  end

  // Sticky timing error; a set in the same cycle as err_clr takes priority.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      timing_err <= 1'b0;
    end else if ((fail && state != UNLOCKED) || timeout1) begin
      timing_err <= 1'b1;
    end else if (err_clr) begin
      timing_err <= 1'b0;
    end
  end

  // Stage 2: registered pixel outputs; position and colour hold when idle.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= lock_nxt && vis1;
      frame_done <= lock_nxt && fstart1;
      if (lock_nxt && vis1) begin
        pix_x   <= px;
        pix_y   <= py;
        pix_rgb <= rgb1;
      end
    end
  end

`ifdef VGA_RX_CELL_EN
  localparam logic [9:0] CELL_MASK = 10'(CELL_SIZE - 1);
  localparam logic [9:0] CELL_MID  = 10'(CELL_SIZE / 2);

  logic cell_hit;

  // Cell-centre sample position within the visible pixel.
  always_comb begin
    cell_hit = lock_nxt && vis1 &&
               ((px & CELL_MASK) == CELL_MID) && ((py & CELL_MASK) == CELL_MID);
  end

  // Stage 2: cell index and occupancy at each cell centre.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cell_valid <= 1'b0;
      cell_x     <= '0;
      cell_y     <= '0;
      cell_on    <= 1'b0;
    end else begin
      cell_valid <= cell_hit;
      if (cell_hit) begin
        cell_x  <= 6'(px / CELL_SIZE);
        cell_y  <= 6'(py / CELL_SIZE);
        cell_on <= |rgb1;
      end
    end
  end
`endif

endmodule
